// File: rtl/wspr_symbol_sequencer_if.sv
// Configuration/start inputs and tone-select/transmit outputs of the WSPR symbol sequencer.
// The master side drives configuration and start; the slave side is the sequencer.
interface wspr_symbol_sequencer_if;
  logic       io_config_start;
  logic [7:0] io_config_bits_in;
  logic       io_config_valid_in;
  logic       io_rf_start;
  logic       io_config_done;
  logic       io_busy;
  logic       io_tx_en;
  logic [1:0] io_symbol;
  logic [7:0] io_symbol_index;
  logic       io_symbol_strobe;

  modport master (
    output io_config_start, io_config_bits_in, io_config_valid_in, io_rf_start,
    input  io_config_done, io_busy, io_tx_en, io_symbol, io_symbol_index, io_symbol_strobe
  );

  modport slave (
    input  io_config_start, io_config_bits_in, io_config_valid_in, io_rf_start,
    output io_config_done, io_busy, io_tx_en, io_symbol, io_symbol_index, io_symbol_strobe
  );
endinterface

// File: rtl/wspr_symbol_sequencer.sv
// WSPR 4-FSK symbol sequencer: loads a packed 2-bit-per-symbol message byte by byte,
// then plays it back one symbol per SYMBOL_CYCLES clocks as a tone select plus RF enable.
module wspr_symbol_sequencer #(
  parameter int NUM_SYMBOLS   = 162,
  parameter int SYMBOL_CYCLES = 6826667,
  parameter int CNT_W         = 23
) (
  input  logic                  clock,
  input  logic                  reset,
  wspr_symbol_sequencer_if.slave io
);

  localparam int NUM_BYTES = (NUM_SYMBOLS + 3) / 4;
  localparam int PTR_W     = $clog2(NUM_BYTES);
  localparam int MEM_W     = 2 * NUM_SYMBOLS;

  localparam logic [PTR_W-1:0] LAST_BYTE = PTR_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [7:0]       LAST_SYM  = 8'(NUM_SYMBOLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_TX
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [MEM_W-1:0] r_mem;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_idx;

  logic       w_write;
  logic       w_tx_go;
  logic       w_sym_end;
  logic       w_msg_end;
  logic       w_in_tx;
  logic [8:0] w_sym_base;

  // A start request during LOAD restarts the load, so it masks any byte offered that cycle.
  assign w_write   = (r_state == ST_LOAD) && !io.io_config_start && io.io_config_valid_in;
  assign w_tx_go   = (r_state == ST_READY) && io.io_rf_start && !io.io_config_start;
  assign w_sym_end = (r_state == ST_TX) && (r_cnt == LAST_CNT);
  assign w_msg_end = w_sym_end && (r_idx == LAST_SYM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (io.io_config_start) w_next = ST_LOAD;
      ST_LOAD:  if (w_write && (r_ptr == LAST_BYTE)) w_next = ST_READY;
      ST_READY: begin
        if (io.io_config_start) w_next = ST_LOAD;
        else if (io.io_rf_start) w_next = ST_TX;
      end
      ST_TX:    if (w_msg_end) w_next = ST_READY;
      default:  w_next = ST_IDLE;
    endcase
  end

  // NOTE: the message store is reset along with everything else, so an aborted load never
  // leaves stale symbols that could be mistaken for a valid message.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is always updated with non-blocking assignments.
      r_mem <= '0;
      r_ptr <= '0;
    end else begin
      if (io.io_config_start && (r_state != ST_TX)) begin
        r_ptr <= '0;
      end else if (w_write) begin
        r_ptr <= r_ptr + 1'b1;
      end
      // Symbols past NUM_SYMBOLS in the final byte have no storage and are dropped.
      if (w_write) begin
        for (int s = 0; s < NUM_SYMBOLS; s++) begin
          if (r_ptr == PTR_W'(s / 4)) r_mem[2*s +: 2] <= io.io_config_bits_in[2*(s%4) +: 2];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tx_go) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_state == ST_TX) begin
      if (w_sym_end) begin
        r_cnt <= '0;
        r_idx <= w_msg_end ? 8'd0 : r_idx + 8'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Outputs decode only flop state, so no input reaches an output combinationally.
  assign w_in_tx    = (r_state == ST_TX);
  assign w_sym_base = {r_idx, 1'b0};

  assign io.io_config_done   = (r_state == ST_READY);
  assign io.io_busy          = w_in_tx;
  assign io.io_tx_en         = w_in_tx;
  assign io.io_symbol        = w_in_tx ? r_mem[w_sym_base +: 2] : 2'd0;
  assign io.io_symbol_index  = w_in_tx ? r_idx : 8'd0;
  assign io.io_symbol_strobe = w_in_tx && (r_cnt == '0);

endmodule

// File: tb/tb_wspr_symbol_sequencer.sv
// Directed self-checking bench for wspr_symbol_sequencer with a 4-cycle symbol period.
module tb_wspr_symbol_sequencer;
  localparam int NS     = 162;
  localparam int SC     = 4;
  localparam int CW     = 3;
  localparam int TX_CYC = NS * SC;

  logic clock = 1'b0;
  logic reset;

  wspr_symbol_sequencer_if io ();

  wspr_symbol_sequencer #(
    .NUM_SYMBOLS  (NS),
    .SYMBOL_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (io)
  );

  always #5 clock = ~clock;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [1:0] gold [NS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io.io_config_start    = 1'b0;
    io.io_config_bits_in  = 8'h00;
    io.io_config_valid_in = 1'b0;
    io.io_rf_start        = 1'b0;
  endtask

  task automatic check_quiet(input string tag, input int done_exp);
    check({tag, ".tx_en"},  32'(io.io_tx_en), 0);
    check({tag, ".busy"},   32'(io.io_busy), 0);
    check({tag, ".symbol"}, 32'(io.io_symbol), 0);
    check({tag, ".index"},  32'(io.io_symbol_index), 0);
    check({tag, ".strobe"}, 32'(io.io_symbol_strobe), 0);
    check({tag, ".done"},   32'(io.io_config_done), 32'(done_exp));
  endtask

  // Byte that must not land in the message store.
  task automatic write_raw(input logic [7:0] b);
    io.io_config_bits_in  = b;
    io.io_config_valid_in = 1'b1;
    step();
    io.io_config_valid_in = 1'b0;
  endtask

  // Byte k of the message; the golden model unpacks it four symbols at a time.
  task automatic send_byte(input logic [7:0] b, input int k);
    write_raw(b);
    for (int j = 0; j < 4; j++) begin
      if (4*k + j < NS) gold[4*k + j] = b[2*j +: 2];
    end
  endtask

  task automatic run_tx(input string tag, input bit lockout);
    int strobes;
    strobes = 0;
    io.io_rf_start = 1'b1;
    step();
    io.io_rf_start = 1'b0;
    for (int c = 0; c < TX_CYC; c++) begin
      check({tag, ".tx_en"},  32'(io.io_tx_en), 1);
      check({tag, ".busy"},   32'(io.io_busy), 1);
      check({tag, ".done"},   32'(io.io_config_done), 0);
      check({tag, ".index"},  32'(io.io_symbol_index), 32'(c / SC));
      check({tag, ".symbol"}, 32'(io.io_symbol), 32'(gold[c / SC]));
      check({tag, ".strobe"}, 32'(io.io_symbol_strobe), 32'(c % SC == 0));
      if (io.io_symbol_strobe) strobes++;
      if (lockout) begin
        io.io_config_start    = (c % 7 == 3);
        io.io_rf_start        = (c % 5 == 1);
        io.io_config_valid_in = (c % 3 == 0);
        io.io_config_bits_in  = 8'hA5;
      end
      step();
    end
    idle_inputs();
    check({tag, ".strobe_count"}, 32'(strobes), NS);
    check_quiet({tag, ".end"}, 1);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) step();
    check_quiet("reset", 0);
    reset = 1'b0;
    step();
    check_quiet("idle", 0);

    // rf_start is ignored while idle.
    io.io_rf_start = 1'b1;
    step();
    io.io_rf_start = 1'b0;
    step();
    check_quiet("idle_rf", 0);

    // Enter LOAD, write some junk, then restart with a valid byte that must be discarded.
    io.io_config_start = 1'b1;
    step();
    io.io_config_start = 1'b0;
    check_quiet("load_entry", 0);
    for (int i = 0; i < 5; i++) write_raw(8'hFF);
    io.io_config_start    = 1'b1;
    io.io_config_valid_in = 1'b1;
    io.io_config_bits_in  = 8'hEE;
    step();
    idle_inputs();
    check("restart.done", 32'(io.io_config_done), 0);

    // Full load with byte k = k; done rises only after the 41st byte.
    for (int k = 0; k < 41; k++) begin
      send_byte(8'(k), k);
      check("load.done", 32'(io.io_config_done), 32'(k == 40));
    end

    // Bytes offered in READY are ignored.
    for (int i = 0; i < 3; i++) write_raw(8'hFF);
    check("ready_bytes.done", 32'(io.io_config_done), 1);

    run_tx("tx1", 1'b0);
    run_tx("tx2_lockout", 1'b1);

    // rf_start and config_start together in READY: load wins.
    io.io_rf_start     = 1'b1;
    io.io_config_start = 1'b1;
    step();
    idle_inputs();
    check_quiet("simul", 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("simul.tx_en", 32'(io.io_tx_en), 0);
    end

    // Gapped random load; done must stay low until the 41st valid byte.
    for (int k = 0; k < 41; k++) begin
      repeat ($urandom_range(0, 3)) step();
      check("gap.done_before", 32'(io.io_config_done), 0);
      send_byte(8'($urandom), k);
      check("gap.done_after", 32'(io.io_config_done), 32'(k == 40));
      step();
    end
    run_tx("tx3", 1'b0);

    // Asynchronous reset mid-transmission.
    io.io_rf_start = 1'b1;
    step();
    io.io_rf_start = 1'b0;
    repeat (10) step();
    check("mid_tx.tx_en", 32'(io.io_tx_en), 1);
    #2 reset = 1'b1;
    #1 check_quiet("async_rst", 0);
    step();
    reset = 1'b0;
    step();
    io.io_rf_start = 1'b1;
    step();
    io.io_rf_start = 1'b0;
    check_quiet("post_rst_rf", 0);
    repeat (5) step();
    check("post_rst.tx_en", 32'(io.io_tx_en), 0);
    check("post_rst.done", 32'(io.io_config_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
